cpu_fpu_float: RTL and testbench
================================

Name: cpu_fpu_float

Overview:
Integer-to-single-precision converter for the FPU, covering FCVT.S.W and FCVT.S.WU. It is the inverse of the FPU float-to-int unit. It accepts a 32-bit integer operand (signed or unsigned) and returns an IEEE-754 binary32 result, rounded to nearest-even. It is multi-cycle, uses a serial one-bit-per-cycle normaliser, and follows the same level-held request/ready handshake as the other FPU sub-units.

Parameters:
None.

Ports:
i_clock   in   1   clock, all logic on rising edge
i_reset   in   1   reset, synchronous, active-high
i_request in   1   level request; held high by the caller until o_ready has been seen
i_op1     in   32  integer operand
i_signed  in   1   1 = treat i_op1 as two's complement (FCVT.S.W); 0 = unsigned (FCVT.S.WU)
o_ready   out  1   result valid; stays high while i_request stays high
o_result  out  32  binary32 result; registered and stable while o_ready=1

Behaviour:
- Reset (i_reset=1 at an edge):
  - o_ready<=0 and state<=IDLE.
  - Reset overrides every other assignment in the same cycle, including mid-conversion.
  - o_result is not cleared by i_reset; its power-up value is 0.
- IDLE:
  - o_ready<=0.
  - When i_request=1: capture sign s = i_signed & i_op1[31].
  - Capture magnitude m = s ? -i_op1 : i_op1 as 32-bit unsigned. 0x80000000 stays 0x80000000, which is correct for -2^31.
  - Set exponent e<=31 (signed, at least 7 bits internally). Go to CHECK.
- CHECK:
  - If m==0: z<=0x00000000 (always +0, never -0), go to DONE.
  - Otherwise go to NORM.
- NORM:
  - If m[31]==0: m<=m<<1, e<=e-1, stay in NORM.
  - Otherwise go to ROUND.
  - Occupies lz+1 cycles, where lz = leading zeros of m (0..31).
- ROUND:
  - Fields: mant = m[30:8]; guard = m[7]; rnd = m[6]; sticky = |m[5:0]; lsb = m[8].
  - Round up when guard & (rnd | sticky | lsb).
  - Round-up with mant==0x7FFFFF: mant<=0, e<=e+1. Exponent overflow is impossible since max e is 32.
  - z <= {s, e+127 (8 bits), mant}. Go to DONE.
  - The result is always exact or correctly rounded. Denormals, Inf and NaN are never produced.
- DONE:
  - Each cycle: o_ready<=1, o_result<=z.
  - If i_request==0 in that cycle: o_ready<=0 (this takes priority), go to IDLE.
  - A new request is accepted only from IDLE, i.e. at least one cycle after i_request is lowered.
- Latency, counted in rising edges from the accepting edge (inclusive) until o_ready reads 1:
  - Nonzero operand: lz+5. Minimum 5 (bit 31 set), maximum 36 (magnitude 1).
  - Zero operand: 3.
- i_op1 and i_signed are sampled only at the accepting edge; later changes are ignored.
- i_request dropping before DONE: the conversion completes, then DONE sees i_request=0 and returns to IDLE without raising o_ready. This aborts cleanly.
- Unused state encodings go to IDLE.

Test Plan:
- Exact values, signed: i_op1=1 → 0x3F800000, o_ready after 36 edges. i_op1=0xFFFFFFFF → 0xBF800000. i_op1=0x80000000 → 0xCF000000 with 5-edge latency.
- Unsigned: i_op1=0xFFFFFFFF, i_signed=0 → rounds up with mantissa overflow to 0x4F800000. i_op1=0x80000000, i_signed=0 → 0x4F000000.
- Ties to even: 0x01000001 → 0x4B800000 (tie, lsb 0, truncate). 0x01000003 → 0x4B800002 (tie, lsb 1, round up). 0x01000005 → 0x4B800002 (tie, lsb 0, truncate).
- Zero: i_op1=0 with i_signed=0 or 1 → 0x00000000, o_ready exactly 3 edges after acceptance.
- Handshake:
  - Hold i_request 10 cycles past ready: o_ready and o_result stay stable.
  - Drop i_request: o_ready=0 on the next edge.
  - Change i_op1 mid-conversion: no effect on the result.
  - Back-to-back requests produce independent results.
- Reset: assert i_reset during NORM for i_op1=1 → o_ready=0, state IDLE. A following request for 7 returns 0x40E00000 correctly.

Source files
------------

// File: rtl/cpu_fpu_float.sv
// Integer to IEEE-754 binary32 converter (FCVT.S.W / FCVT.S.WU), round to nearest-even.
// Serial normaliser shifts one bit per cycle; level-held request/ready handshake.
module cpu_fpu_float (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_op1,
  input  logic        i_signed,
  output logic        o_ready,
  output logic [31:0] o_result
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic        [31:0] m_r, m_s;
  logic signed [7:0]  e_r, e_s;
  logic               sign_r, sign_s;
  logic        [31:0] z_r, z_s;
  logic               ready_s;
  logic        [31:0] result_s;
  logic               neg_s;

  // Packs a normalised magnitude (bit 31 set) into binary32 with ties-to-even.
  // Exponent is at most 32, so the mantissa carry can never overflow the field.
  function automatic logic [31:0] round_pack(input logic sign, input logic [7:0] exp,
                                             input logic [31:0] mag);
    logic [22:0] mant;
    logic [7:0]  bexp;
    logic        guard, rnd, sticky, lsb;
    mant   = mag[30:8];
    guard  = mag[7];
    rnd    = mag[6];
    sticky = |mag[5:0];
    lsb    = mag[8];
    bexp   = exp + 8'd127;
    if (guard & (rnd | sticky | lsb)) begin
      if (mant == 23'h7FFFFF) begin
        mant = 23'd0;
        bexp = bexp + 8'd1;
      end else begin
        mant = mant + 23'd1;
      end
    end else begin
      mant = mant;
    end
    return {sign, bexp, mant};
  endfunction

  assign neg_s = i_signed & i_op1[31];

  // Next-state and datapath update logic.
  always_comb begin
    state_s  = state_r;
    m_s      = m_r;
    e_s      = e_r;
    sign_s   = sign_r;
    z_s      = z_r;
    ready_s  = 1'b0;
    result_s = o_result;
    case (state_r)
      IDLE: begin
        if (i_request) begin
          sign_s  = neg_s;
          m_s     = neg_s ? (32'd0 - i_op1) : i_op1;
          e_s     = 8'sd31;
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (m_r == 32'd0) begin
          z_s     = 32'd0;
          state_s = DONE;
        end else begin
          state_s = NORM;
        end
      end
      NORM: begin
        if (!m_r[31]) begin
          m_s = {m_r[30:0], 1'b0};
          e_s = e_r - 8'sd1;
        end else begin
          state_s = ROUND;
        end
      end
      ROUND: begin
        z_s     = round_pack(sign_r, e_r, m_r);
        state_s = DONE;
      end
      DONE: begin
        result_s = z_r;
        if (i_request) begin
          ready_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control registers; reset returns to IDLE with ready low.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r <= IDLE;
      o_ready <= 1'b0;
    end else begin
      state_r <= state_s;
      o_ready <= ready_s;
    end
  end

  // Datapath registers; result is deliberately not cleared by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      m_r <= m_r;
    end else begin
      m_r      <= m_s;
      e_r      <= e_s;
      sign_r   <= sign_s;
      z_r      <= z_s;
      o_result <= result_s;
    end
  end

endmodule

// File: tb/tb_cpu_fpu_float.sv
// Scoreboard bench for cpu_fpu_float: driver pushes model results, monitor checks value and latency.
module tb_cpu_fpu_float;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_request;
  logic [31:0] i_op1;
  logic        i_signed;
  logic        o_ready;
  logic [31:0] o_result;

  cpu_fpu_float dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_request(i_request),
    .i_op1    (i_op1),
    .i_signed (i_signed),
    .o_ready  (o_ready),
    .o_result (o_result)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  // Reference: find the leading one, keep 24 significant bits, round the rest to nearest-even.
  function automatic logic [31:0] ref_conv(input logic [31:0] op, input logic sgn, output int lat);
    logic [63:0] mag, q, rem, half;
    logic        neg;
    int          p, sh;
    neg = sgn && op[31];
    mag = neg ? (64'h1_0000_0000 - {32'd0, op}) : {32'd0, op};
    if (mag == 64'd0) begin
      lat = 3;
      return 32'd0;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    lat = 36 - p;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    return {neg, 8'(p + 127), q[22:0]};
  endfunction

  // Monitor: on each ready rise pop and check value and latency; while held check stability.
  initial begin
    logic        prev_ready;
    logic [31:0] cur_exp;
    exp_t        e;
    int          lat;
    prev_ready = 1'b0;
    cur_exp    = 32'd0;
    forever begin
      @(negedge i_clock);
      if (o_ready === 1'b1) begin
        if (!prev_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ready: got result=%08h with no request outstanding", o_result);
          end else begin
            e = exp_q.pop_front();
            cur_exp = e.res;
            if (o_result !== e.res) begin
              bad++;
              $display("FAIL result: got %08h expected %08h", o_result, e.res);
            end
            total++;
            lat = cyc - e.acc + 1;
            if (lat != e.lat) begin
              bad++;
              $display("FAIL latency: got %0d expected %0d (result %08h)", lat, e.lat, e.res);
            end
          end
        end else begin
          total++;
          if (o_result !== cur_exp) begin
            bad++;
            $display("FAIL stable: got %08h expected %08h", o_result, cur_exp);
          end
        end
      end
      prev_ready = (o_ready === 1'b1);
    end
  end

  task automatic convert(input logic [31:0] op, input logic sgn, input int hold);
    int          lat, n;
    logic [31:0] r;
    exp_t        e;
    @(negedge i_clock);
    i_request = 1'b1;
    i_op1     = op;
    i_signed  = sgn;
    r = ref_conv(op, sgn, lat);
    e.res = r;
    e.lat = lat;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge i_clock);
    n = 0;
    while (o_ready !== 1'b1 && n < 60) begin
      i_op1    = $urandom;
      i_signed = 1'($urandom_range(0, 1));
      @(negedge i_clock);
      n++;
    end
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("FAIL timeout: no ready for op=%08h signed=%0d", op, sgn);
    end
    repeat (hold) @(negedge i_clock);
    i_request = 1'b0;
    @(negedge i_clock);
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL drop: ready=%0b expected 0 after request lowered", o_ready);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge i_clock);
      if (o_ready !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL %s: ready=1 seen expected 0", name);
    end
  endtask

  task automatic abort_conv(input logic [31:0] op, input int k);
    @(negedge i_clock);
    i_request = 1'b1;
    i_op1     = op;
    i_signed  = 1'b1;
    repeat (k) @(negedge i_clock);
    i_request = 1'b0;
    expect_quiet("abort", 45);
  endtask

  initial begin
    logic [31:0] op;
    i_reset   = 1'b1;
    i_request = 1'b0;
    i_op1     = 32'd0;
    i_signed  = 1'b0;
    repeat (3) @(negedge i_clock);
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got %0b expected 0", o_ready);
    end
    i_reset = 1'b0;

    convert(32'h00000001, 1'b1, 0);
    convert(32'hFFFFFFFF, 1'b1, 1);
    convert(32'h80000000, 1'b1, 0);
    convert(32'hFFFFFFFF, 1'b0, 0);
    convert(32'h80000000, 1'b0, 2);
    convert(32'h01000001, 1'b1, 0);
    convert(32'h01000003, 1'b0, 0);
    convert(32'h01000005, 1'b1, 0);
    convert(32'h00000000, 1'b0, 0);
    convert(32'h00000000, 1'b1, 0);
    convert(32'h00FFFFFF, 1'b0, 10);
    convert(32'h12345678, 1'b1, 0);
    convert(32'h12345678, 1'b1, 0);

    // Reset while normalising, then a fresh conversion must be clean.
    @(negedge i_clock);
    i_request = 1'b1;
    i_op1     = 32'd1;
    i_signed  = 1'b1;
    repeat (10) @(negedge i_clock);
    i_reset   = 1'b1;
    i_request = 1'b0;
    @(negedge i_clock);
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ready=%0b expected 0", o_ready);
    end
    i_reset = 1'b0;
    expect_quiet("after_reset", 40);
    convert(32'd7, 1'b1, 0);

    abort_conv(32'h00000001, 3);
    abort_conv(32'h40000000, 1);

    for (int i = 0; i < 150; i++) begin
      op = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) op = 32'd0 - op;
      convert(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      if (i % 40 == 39) abort_conv($urandom, int'($urandom_range(1, 4)));
    end

    repeat (5) @(negedge i_clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d results never returned, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
